// File: rtl/exec_stage_pkg.sv
// Shared constants for the MIPS execute stage:
// ALU control codes, main-control ALU ops and R-type funct values.
package exec_stage_pkg;

    typedef enum logic [3:0] {
        ALU_AND = 4'b0000,
        ALU_OR  = 4'b0001,
        ALU_ADD = 4'b0010,
        ALU_SUB = 4'b0110,
        ALU_SLT = 4'b0111,
        ALU_NOR = 4'b1100
    } alu_ctl_e;

    localparam logic [1:0] AOP_MEM   = 2'b00;
    localparam logic [1:0] AOP_BR    = 2'b01;
    localparam logic [1:0] AOP_RTYPE = 2'b10;
    localparam logic [1:0] AOP_RSVD  = 2'b11;

    localparam logic [5:0] FN_ADD = 6'b100000;
    localparam logic [5:0] FN_SUB = 6'b100010;
    localparam logic [5:0] FN_AND = 6'b100100;
    localparam logic [5:0] FN_OR  = 6'b100101;
    localparam logic [5:0] FN_SLT = 6'b101010;
    localparam logic [5:0] FN_NOR = 6'b100111;

endpackage

// File: rtl/exec_stage_alu_decoder.sv
// ALU control decoder: maps main-control ALU op and funct
// field to the 4-bit ALU control code.
module alu_decoder
    import exec_stage_pkg::*;
(
    input  logic [1:0] aluOp,
    input  logic [5:0] funcCode,
    output logic [3:0] aluCtl
);

    // Loads/stores and the reserved op add; branches subtract.
    always_comb begin
        aluCtl = ALU_ADD;
        case (aluOp)
            AOP_BR: aluCtl = ALU_SUB;
            AOP_RTYPE: begin
                case (funcCode)
                    FN_ADD:  aluCtl = ALU_ADD;
                    FN_SUB:  aluCtl = ALU_SUB;
                    FN_AND:  aluCtl = ALU_AND;
                    FN_OR:   aluCtl = ALU_OR;
                    FN_SLT:  aluCtl = ALU_SLT;
                    FN_NOR:  aluCtl = ALU_NOR;
                    default: aluCtl = ALU_ADD;
                endcase
            end
            default: aluCtl = ALU_ADD;
        endcase
    end

endmodule

// File: rtl/exec_stage.sv
// Registered MIPS execute stage: ALU, zero flag, PC+4 and
// branch-target adders, all behind a one-cycle output register.
module exec_stage
    import exec_stage_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clock,
    input  logic             resetN,
    input  logic [1:0]       aluOp,
    input  logic [5:0]       funcCode,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic [WIDTH-1:0] pc,
    input  logic [WIDTH-1:0] imm,
    output logic [3:0]       aluCtl,
    output logic [WIDTH-1:0] aluResult,
    output logic             zero,
    output logic [WIDTH-1:0] pcPlus4,
    output logic [WIDTH-1:0] branchTarget
);

    logic [3:0]       w_aluCtl;
    logic [WIDTH-1:0] w_aluResult;
    logic             w_zero;
    logic [WIDTH-1:0] w_pcPlus4;
    logic [WIDTH-1:0] w_branchTarget;

    alu_decoder u_dec (
        .aluOp    (aluOp),
        .funcCode (funcCode),
        .aluCtl   (w_aluCtl)
    );

    // ALU datapath; unknown control codes produce zero.
    always_comb begin
        w_aluResult = '0;
        case (w_aluCtl)
            ALU_AND: w_aluResult = a & b;
            ALU_OR:  w_aluResult = a | b;
            ALU_ADD: w_aluResult = a + b;
            ALU_SUB: w_aluResult = a - b;
            ALU_SLT: w_aluResult = {{(WIDTH-1){1'b0}},
                                    ($signed(a) < $signed(b))};
            ALU_NOR: w_aluResult = ~(a | b);
            default: w_aluResult = '0;
        endcase
    end

    assign w_zero         = (w_aluResult == '0);
    assign w_pcPlus4      = pc + WIDTH'(4);
    // Word offset: the shift drops the top two immediate bits.
    assign w_branchTarget = w_pcPlus4 + (imm << 2);

    // Output register with synchronous active-low clear.
    always_ff @(posedge clock) begin
        if (!resetN) begin
            aluCtl       <= '0;
            aluResult    <= '0;
            zero         <= 1'b0;
            pcPlus4      <= '0;
            branchTarget <= '0;
        end else begin
            aluCtl       <= w_aluCtl;
            aluResult    <= w_aluResult;
            zero         <= w_zero;
            pcPlus4      <= w_pcPlus4;
            branchTarget <= w_branchTarget;
        end
    end

endmodule

// File: tb/tb_exec_stage.sv
// Self-checking bench for exec_stage: vector table plus
// scoreboard queue, with reset and mid-stream reset sequences.
module tb_exec_stage;

    logic        clock = 1'b0;
    logic        resetN = 1'b0;
    logic [1:0]  aluOp = 2'b00;
    logic [5:0]  funcCode = 6'b0;
    logic [31:0] a = '0, b = '0, pc = '0, imm = '0;
    logic [3:0]  aluCtl;
    logic [31:0] aluResult, pcPlus4, branchTarget;
    logic        zero;

    typedef struct {
        logic [3:0]  ctl;
        logic [31:0] res;
        logic        z;
        logic [31:0] p4;
        logic [31:0] bt;
    } exp_t;

    typedef struct {
        string       name;
        logic [1:0]  op;
        logic [5:0]  fn;
        logic [31:0] a, b, pc, imm;
        exp_t        e;
    } vec_t;

    exp_t   sb_q[$];
    string  nm_q[$];
    vec_t   vecs[$];
    int     n_checks = 0;
    int     n_fail = 0;

    exec_stage #(.WIDTH(32)) dut (
        .clock        (clock),
        .resetN       (resetN),
        .aluOp        (aluOp),
        .funcCode     (funcCode),
        .a            (a),
        .b            (b),
        .pc           (pc),
        .imm          (imm),
        .aluCtl       (aluCtl),
        .aluResult    (aluResult),
        .zero         (zero),
        .pcPlus4      (pcPlus4),
        .branchTarget (branchTarget)
    );

    always #5 clock = ~clock;

    function automatic vec_t mk(string n, logic [1:0] op,
                                logic [5:0] fn,
                                logic [31:0] va, logic [31:0] vb,
                                logic [31:0] vpc, logic [31:0] vimm,
                                logic [3:0] ctl, logic [31:0] res,
                                logic z, logic [31:0] p4,
                                logic [31:0] bt);
        vec_t v;
        v.name = n; v.op = op; v.fn = fn;
        v.a = va; v.b = vb; v.pc = vpc; v.imm = vimm;
        v.e.ctl = ctl; v.e.res = res; v.e.z = z;
        v.e.p4 = p4; v.e.bt = bt;
        return v;
    endfunction

    task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", n, act, exp);
        end
    endtask

    // Drive one operation at the falling edge and queue its expectation.
    task automatic drive(vec_t v, logic rst_n);
        exp_t e;
        @(negedge clock);
        aluOp = v.op; funcCode = v.fn;
        a = v.a; b = v.b; pc = v.pc; imm = v.imm;
        resetN = rst_n;
        if (rst_n) e = v.e;
        else e = '{ctl: 4'h0, res: 32'h0, z: 1'b0, p4: 32'h0, bt: 32'h0};
        sb_q.push_back(e);
        nm_q.push_back(rst_n ? v.name : {v.name, "_rst"});
    endtask

    // Compare registered outputs just after each rising edge.
    always @(posedge clock) begin
        exp_t  e;
        string n;
        #1;
        if (sb_q.size() > 0) begin
            e = sb_q.pop_front();
            n = nm_q.pop_front();
            chk({n, ".ctl"}, {28'h0, aluCtl}, {28'h0, e.ctl});
            chk({n, ".res"}, aluResult, e.res);
            chk({n, ".zero"}, {31'h0, zero}, {31'h0, e.z});
            chk({n, ".pc4"}, pcPlus4, e.p4);
            chk({n, ".bt"}, branchTarget, e.bt);
        end
    end

    initial begin
        vec_t v_rst, v_add, v_sub, v_or, v_nor;
        int   wait_cyc;

        v_rst = mk("reset", 2'b10, 6'b100000, 32'd5, 32'd3, 32'h0,
                   32'h0, 4'h0, 32'h0, 1'b0, 32'h0, 32'h0);
        v_add = mk("add", 2'b10, 6'b100000, 32'hC, 32'hA, 32'h0,
                   32'h0, 4'b0010, 32'h16, 1'b0, 32'h4, 32'h4);
        v_sub = mk("sub", 2'b10, 6'b100010, 32'hC, 32'hA, 32'h0,
                   32'h0, 4'b0110, 32'h2, 1'b0, 32'h4, 32'h4);
        v_or  = mk("or", 2'b10, 6'b100101, 32'hC, 32'hA, 32'h0,
                   32'h0, 4'b0001, 32'hE, 1'b0, 32'h4, 32'h4);
        v_nor = mk("nor", 2'b10, 6'b100111, 32'hC, 32'hA, 32'h0,
                   32'h0, 4'b1100, 32'hFFFFFFF1, 1'b0, 32'h4, 32'h4);

        vecs.push_back(v_add);
        vecs.push_back(v_sub);
        vecs.push_back(mk("and", 2'b10, 6'b100100, 32'hC, 32'hA,
                   32'h0, 32'h0, 4'b0000, 32'h8, 1'b0, 32'h4, 32'h4));
        vecs.push_back(v_or);
        vecs.push_back(v_nor);
        vecs.push_back(mk("slt", 2'b10, 6'b101010, 32'hC, 32'hA,
                   32'h0, 32'h0, 4'b0111, 32'h0, 1'b1, 32'h4, 32'h4));
        vecs.push_back(mk("slt_neg", 2'b10, 6'b101010, 32'hFFFFFFFF,
                   32'h1, 32'h0, 32'h0, 4'b0111, 32'h1, 1'b0,
                   32'h4, 32'h4));
        vecs.push_back(mk("undef_fn", 2'b10, 6'b000000, 32'hFFFFFFFF,
                   32'h1, 32'h0, 32'h0, 4'b0010, 32'h0, 1'b1,
                   32'h4, 32'h4));
        vecs.push_back(mk("beq_eq", 2'b01, 6'b000000, 32'h1234,
                   32'h1234, 32'h0, 32'h0, 4'b0110, 32'h0, 1'b1,
                   32'h4, 32'h4));
        vecs.push_back(mk("beq_ne", 2'b01, 6'b101010, 32'h1234,
                   32'h1235, 32'h0, 32'h0, 4'b0110, 32'hFFFFFFFF,
                   1'b0, 32'h4, 32'h4));
        vecs.push_back(mk("rsvd_op", 2'b11, 6'b100010, 32'h3, 32'h4,
                   32'h0, 32'h0, 4'b0010, 32'h7, 1'b0, 32'h4, 32'h4));
        vecs.push_back(mk("lw_addr", 2'b00, 6'b100100, 32'h100, 32'h8,
                   32'h40, 32'hFFFFFFFE, 4'b0010, 32'h108, 1'b0,
                   32'h44, 32'h3C));
        vecs.push_back(mk("pc_wrap", 2'b00, 6'b000000, 32'h7FFFFFFF,
                   32'h1, 32'hFFFFFFFC, 32'h1, 4'b0010, 32'h80000000,
                   1'b0, 32'h0, 32'h4));
        vecs.push_back(mk("imm_top", 2'b00, 6'b000000, 32'h0, 32'h0,
                   32'h0, 32'h40000001, 4'b0010, 32'h0, 1'b1,
                   32'h4, 32'h8));

        drive(v_rst, 1'b0);
        foreach (vecs[i]) drive(vecs[i], 1'b1);

        // Back-to-back ops with a one-cycle reset in the middle.
        drive(v_add, 1'b1);
        drive(v_sub, 1'b1);
        drive(v_or, 1'b0);
        drive(v_nor, 1'b1);
        drive(v_add, 1'b1);

        wait_cyc = 0;
        while (sb_q.size() > 0 && wait_cyc < 20) begin
            @(negedge clock);
            wait_cyc++;
        end
        if (sb_q.size() > 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL drain: %0d pending, expected 0", sb_q.size());
        end
        @(negedge clock);
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_checks, n_fail);
        $finish;
    end

endmodule
